// File: rtl/lzs_pkg.sv
// lzs_pkg: shared state encoding, width helper and default widths for the LZS decode path
package lzs_pkg;
  localparam int LZS_IN_W = 16;
  localparam int LZS_PEEK_W = 13;
  typedef enum logic [1:0] {S_FILL, S_RUN, S_DRAIN, S_DONE} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = v - 1; i > 0; i = i >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/lzs_bit_shifter.sv
// lzs_bit_shifter: left-shift the bit buffer with zero fill and OR a new word in at a bit offset from the MSB
module lzs_bit_shifter #(
  parameter int BUF_W = 48,
  parameter int IN_W = 16,
  parameter int CNT_W = 6
) (
  input  logic [BUF_W-1:0] buf_in,
  input  logic [CNT_W-1:0] sh,
  input  logic [IN_W-1:0]  word,
  input  logic             ins,
  input  logic [CNT_W-1:0] off,
  output logic [BUF_W-1:0] buf_out
);
  logic [BUF_W-1:0] placed;
  // Bits below the post-shift count are zero, so an OR is enough to merge.
  always_comb begin
    placed = {word, {(BUF_W-IN_W){1'b0}}} >> off;
    buf_out = (buf_in << sh) | (ins ? placed : '0);
  end
endmodule

// File: rtl/lzs_bit_unpacker.sv
// lzs_bit_unpacker: MSB-first bit-stream unpacker with variable-width consume, alignment and end-of-stream drain
module lzs_bit_unpacker
  import lzs_pkg::*;
#(
  parameter int IN_W = LZS_IN_W,
  parameter int PEEK_W = LZS_PEEK_W,
  parameter int BUF_W = 48,
  parameter int ALIGN_W = 8,
  parameter int POS_W = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic [IN_W-1:0]             in_data,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic [PEEK_W-1:0]           peek_data,
  output logic                        peek_valid,
  input  logic                        consume,
  input  logic [clog2(PEEK_W+1)-1:0]  consume_width,
  input  logic                        align,
  output logic [POS_W-1:0]            bit_pos,
  output logic                        done,
  output logic                        err
);
  localparam int CNT_W = clog2(BUF_W + 1);
  state_t state, state_n;
  logic [BUF_W-1:0] buffer, shifted, buf_n;
  logic [CNT_W-1:0] cnt, cnt_n, w_ext, d_raw, d, take;
  logic last_seen, last_n, cons_go, align_go, over, accept;
  assign in_ready = !last_seen && (cnt <= CNT_W'(BUF_W - IN_W));
  assign peek_valid = (cnt >= CNT_W'(PEEK_W)) || (last_seen && cnt != '0);
  assign peek_data = buffer[BUF_W-1 -: PEEK_W];
  assign done = (state == S_DONE);
  always_comb begin
    cons_go = consume && peek_valid;
    align_go = align && !consume && cnt != '0;
    w_ext = CNT_W'(consume_width);
    over = cons_go && w_ext > cnt;
    // Distance to the next alignment boundary: (-bit_pos) mod ALIGN_W.
    d_raw = (~bit_pos[CNT_W-1:0] + 1'b1) & CNT_W'(ALIGN_W - 1);
    d = d_raw > cnt ? cnt : d_raw;
    take = cons_go ? (over ? cnt : w_ext) : (align_go ? d : '0);
    accept = in_valid && in_ready;
    cnt_n = cnt - take + (accept ? CNT_W'(IN_W) : '0);
    last_n = last_seen || (accept && in_last);
    buf_n = over ? '0 : shifted;
  end
  lzs_bit_shifter #(.BUF_W(BUF_W), .IN_W(IN_W), .CNT_W(CNT_W)) u_shifter (
    .buf_in(buffer),
    .sh(take),
    .word(in_data),
    .ins(accept),
    .off(cnt - take),
    .buf_out(shifted)
  );
  always_comb begin
    state_n = state;
    if (state != S_DONE)
      state_n = last_n ? (cnt_n == '0 ? S_DONE : S_DRAIN) : (cnt_n >= CNT_W'(PEEK_W) ? S_RUN : S_FILL);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_FILL;
    else state <= clr ? S_FILL : state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      buffer <= '0;
      cnt <= '0;
      bit_pos <= '0;
      last_seen <= 1'b0;
      err <= 1'b0;
    end else if (clr) begin
      buffer <= '0;
      cnt <= '0;
      bit_pos <= '0;
      last_seen <= 1'b0;
      err <= 1'b0;
    end else begin
      buffer <= buf_n;
      cnt <= cnt_n;
      bit_pos <= bit_pos + POS_W'(take);
      last_seen <= last_n;
      err <= err || over;
    end
endmodule

// File: tb/tb_lzs_bit_unpacker.sv
// tb_lzs_bit_unpacker: directed table, corner sequences and random traffic against a bit-queue reference model
module tb_lzs_bit_unpacker;
  localparam int IN_W = 16, PEEK_W = 13, BUF_W = 48, ALIGN_W = 8, POS_W = 32;
  logic clk = 0, rst = 1, clr = 0, in_valid = 0, in_last = 0, consume = 0, align = 0;
  logic [IN_W-1:0] in_data = '0;
  logic [3:0] consume_width = '0;
  logic [PEEK_W-1:0] peek_data;
  logic peek_valid, in_ready, done, err;
  logic [POS_W-1:0] bit_pos;
  int checks = 0, failures = 0;
  bit q[$];
  bit m_last, m_err;
  longint unsigned m_pos;
  typedef struct {
    bit r, v;
    logic [15:0] d;
    bit c;
    int w;
    logic [12:0] pk;
    bit pv, rdy;
    int pos;
  } vec_t;
  vec_t tv[11];

  always #5 clk = ~clk;

  lzs_bit_unpacker #(.IN_W(IN_W), .PEEK_W(PEEK_W), .BUF_W(BUF_W), .ALIGN_W(ALIGN_W), .POS_W(POS_W)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .peek_data(peek_data), .peek_valid(peek_valid),
    .consume(consume), .consume_width(consume_width), .align(align),
    .bit_pos(bit_pos), .done(done), .err(err)
  );

  function automatic void m_reset();
    q.delete();
    m_last = 0;
    m_err = 0;
    m_pos = 0;
  endfunction

  function automatic logic [PEEK_W-1:0] m_peek();
    logic [PEEK_W-1:0] r = '0;
    for (int i = 0; i < PEEK_W; i++) if (i < q.size()) r[PEEK_W-1-i] = q[i];
    return r;
  endfunction

  function automatic bit m_pv();
    return q.size() >= PEEK_W || (m_last && q.size() != 0);
  endfunction

  function automatic bit m_rdy();
    return !m_last && q.size() <= BUF_W - IN_W;
  endfunction

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic check_all();
    chk("in_ready", 64'(in_ready), 64'(m_rdy()));
    chk("peek_valid", 64'(peek_valid), 64'(m_pv()));
    chk("peek_data", 64'(peek_data), 64'(m_peek()));
    chk("bit_pos", 64'(bit_pos), m_pos & 64'hFFFF_FFFF);
    chk("done", 64'(done), 64'(m_last && q.size() == 0));
    chk("err", 64'(err), 64'(m_err));
  endtask

  task automatic cyc(input bit c_clr, input bit v, input logic [15:0] d, input bit l,
                     input bit c, input int w, input bit a);
    int take;
    bit pv, rdy;
    clr = c_clr; in_valid = v; in_data = d; in_last = l;
    consume = c; consume_width = 4'(w); align = a;
    check_all();
    pv = m_pv();
    rdy = m_rdy();
    take = 0;
    if (c_clr) m_reset();
    else begin
      if (c && pv) begin
        if (w > q.size()) begin
          take = q.size();
          m_err = 1;
        end else take = w;
      end else if (a && !c && q.size() != 0) begin
        take = (ALIGN_W - int'(m_pos % ALIGN_W)) % ALIGN_W;
        if (take > q.size()) take = q.size();
      end
      repeat (take) void'(q.pop_front());
      m_pos += longint'(take);
      if (v && rdy) begin
        for (int i = IN_W - 1; i >= 0; i--) q.push_back(d[i]);
        if (l) m_last = 1;
      end
    end
    @(posedge clk);
    #1;
    clr = 0; in_valid = 0; in_last = 0; consume = 0; align = 0;
  endtask

  initial begin
    tv[0]  = '{0, 1, 16'hA5A5, 0, 0,  13'h14B4, 1, 1, 0};
    tv[1]  = '{0, 1, 16'h0F0F, 0, 0,  13'h14B4, 1, 1, 0};
    tv[2]  = '{0, 0, 16'h0000, 1, 9,  13'h0943, 1, 1, 9};
    tv[3]  = '{1, 0, 16'h0000, 0, 0,  13'h0000, 0, 1, 0};
    tv[4]  = '{0, 1, 16'h1234, 0, 0,  13'h0246, 1, 1, 0};
    tv[5]  = '{0, 1, 16'h5678, 0, 0,  13'h0246, 1, 1, 0};
    tv[6]  = '{0, 1, 16'h9ABC, 0, 0,  13'h0246, 1, 0, 0};
    tv[7]  = '{0, 0, 16'h0000, 1, 13, 13'h1159, 1, 0, 13};
    tv[8]  = '{0, 1, 16'hFFFF, 1, 3,  13'h0ACF, 1, 1, 16};
    tv[9]  = '{0, 0, 16'h0000, 1, 12, 13'h1135, 1, 1, 28};
    tv[10] = '{0, 1, 16'hC3C3, 1, 13, 13'h0F30, 1, 1, 41};
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 11; i++) begin
      cyc(tv[i].r, tv[i].v, tv[i].d, 0, tv[i].c, tv[i].w, 0);
      chk($sformatf("tv%0d_peek", i), 64'(peek_data), 64'(tv[i].pk));
      chk($sformatf("tv%0d_pv", i), 64'(peek_valid), 64'(tv[i].pv));
      chk($sformatf("tv%0d_ready", i), 64'(in_ready), 64'(tv[i].rdy));
      chk($sformatf("tv%0d_pos", i), 64'(bit_pos), 64'(tv[i].pos));
    end
    // drain with zero padding
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 16'h8001, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 13, 0);
    chk("drain_peek", 64'(peek_data), 64'h0400);
    chk("drain_pv", 64'(peek_valid), 64'd1);
    chk("drain_ready", 64'(in_ready), 64'd0);
    chk("drain_done0", 64'(done), 64'd0);
    cyc(0, 0, 0, 0, 1, 3, 0);
    chk("drain_done1", 64'(done), 64'd1);
    chk("drain_ready2", 64'(in_ready), 64'd0);
    // alignment
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 16'hFFFF, 0, 0, 0, 0);
    cyc(0, 1, 16'hFFFF, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 3, 0);
    chk("align_pre", 64'(bit_pos), 64'd3);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("align_first", 64'(bit_pos), 64'd8);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("align_second", 64'(bit_pos), 64'd8);
    cyc(0, 0, 0, 0, 1, 2, 1);
    chk("align_dropped", 64'(bit_pos), 64'd10);
    // over-consume
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 16'hFFFF, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 13, 0);
    cyc(0, 0, 0, 0, 1, 5, 0);
    chk("over_err", 64'(err), 64'd1);
    chk("over_pos", 64'(bit_pos), 64'd16);
    chk("over_done", 64'(done), 64'd1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("over_sticky", 64'(err), 64'd1);
    cyc(1, 1, 16'hFFFF, 1, 1, 5, 1);
    chk("clr_err", 64'(err), 64'd0);
    chk("clr_ready", 64'(in_ready), 64'd1);
    chk("clr_done", 64'(done), 64'd0);
    // asynchronous reset mid-stream
    cyc(0, 1, 16'h1357, 0, 0, 0, 0);
    cyc(0, 1, 16'h2468, 0, 1, 4, 0);
    rst = 1;
    #1;
    m_reset();
    check_all();
    #1;
    rst = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, 16'($urandom),
          $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
          int'($urandom_range(0, 13)), $urandom_range(0, 7) == 0);
    check_all();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
